sort_8x8b_packer: RTL and testbench

SORT_8X8B_PACKER -- requirements
Module: sort_8x8b_packer

---
 rtl/sort_pkg.sv | 22 ++
 rtl/sort_frame_buf.sv | 45 ++++
 rtl/sort_8x8b_packer.sv | 124 ++++++++++++
 tb/tb_sort_8x8b_packer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing for the 8x8-bit sort pipeline (packer and sorter stages).
package sort_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned DATA_W     = LANES * LANE_W;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sort_frame_buf.sv
// Output frame register with valid/ready hold; accepts a push whenever the slot is free.
module sort_frame_buf
  import sort_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_valid,
  input  frame_t push_frame,
  output logic   slot_free_c,
  input  logic   out_ready,
  output logic   out_valid,
  output frame_t out_frame
);

  logic   valid_q, valid_d;
  frame_t frame_q, frame_d;

  // Slot is usable if empty or being drained on this edge.
  assign slot_free_c = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    frame_d = frame_q;
    if (push_valid) begin
      valid_d = 1'b1;
      frame_d = push_frame;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else begin
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign out_valid = valid_q;
  assign out_frame = frame_q;

endmodule

// File: rtl/sort_8x8b_packer.sv
// Packs a byte stream into padded 8-lane frames for the 8x8-bit sorter; fill buffer plus output register.
module sort_8x8b_packer
  import sort_pkg::*;
#(
  parameter logic [LANE_W-1:0] PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  pack_state_e       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              in_ready_q, in_ready_d;

  logic              accept_c;
  logic              close_c;
  lane_idx_t         lane_c;
  logic [CNT_W-1:0]  close_count_c;
  logic [DATA_W-1:0] asm_c;
  logic              push_valid_c;
  frame_t            push_frame_c;
  logic              slot_free_c;
  frame_t            ob_frame;

  assign accept_c      = in_valid && in_ready_q;
  assign lane_c        = count_q[LANE_IDX_W-1:0];
  assign close_count_c = count_q + CNT_W'(1);
  assign close_c       = in_last || (count_q == CNT_W'(LANES - 1));

  // Fill buffer with the incoming byte in its lane; lanes above it are padded.
  always_comb begin
    asm_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < 32'(lane_c)) begin
        asm_c[i*LANE_W +: LANE_W] = fill_q[i*LANE_W +: LANE_W];
      end else if (i == 32'(lane_c)) begin
        asm_c[i*LANE_W +: LANE_W] = in_data;
      end else begin
        asm_c[i*LANE_W +: LANE_W] = PAD_BYTE;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    fill_d             = fill_q;
    push_valid_c       = 1'b0;
    push_frame_c.count = close_count_c;
    push_frame_c.data  = asm_c;
    case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          fill_d = asm_c;
          if (close_c) begin
            if (slot_free_c) begin
              push_valid_c = 1'b1;
              count_d      = '0;
            end else begin
              state_d = ST_HOLD;
              count_d = close_count_c;
            end
          end else begin
            count_d = close_count_c;
          end
        end
      end
      ST_HOLD: begin
        // Output register is full here, so a free slot means a frame handshake.
        push_frame_c.count = count_q;
        push_frame_c.data  = fill_q;
        if (slot_free_c) begin
          push_valid_c = 1'b1;
          state_d      = ST_FILL;
          count_d      = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        count_d = '0;
      end
    endcase
    in_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      count_q    <= '0;
      fill_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fill_q     <= fill_d;
      in_ready_q <= in_ready_d;
    end
  end

  sort_frame_buf u_frame_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid_c),
    .push_frame  (push_frame_c),
    .slot_free_c (slot_free_c),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_frame   (ob_frame)
  );

  assign in_ready  = in_ready_q;
  assign out_data  = ob_frame.data;
  assign out_count = ob_frame.count;

endmodule

// File: tb/tb_sort_8x8b_packer.sv
// Directed bench for sort_8x8b_packer: two instances (pad 00 / pad FF) driven with identical stimulus.
module tb_sort_8x8b_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [63:0] out_data0, out_data1;
  logic [3:0]  out_count0, out_count1;

  int checks = 0;
  int errors = 0;

  sort_8x8b_packer #(.PAD_BYTE(8'h00)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0)
  );

  sort_8x8b_packer #(.PAD_BYTE(8'hFF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        last;
    logic [63:0] din;
    logic [63:0] exp0;
    logic [63:0] expff;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rdy(input string name, input logic exp);
    chk({name, ".in_ready0"}, 64'(in_ready0), 64'(exp));
    chk({name, ".in_ready1"}, 64'(in_ready1), 64'(exp));
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".out_valid0"}, 64'(out_valid0), 64'd0);
    chk({name, ".out_valid1"}, 64'(out_valid1), 64'd0);
  endtask

  task automatic chk_out(input string name, input logic [63:0] d0, input logic [63:0] dff,
                         input logic [3:0] cnt);
    chk({name, ".out_valid0"}, 64'(out_valid0), 64'd1);
    chk({name, ".out_valid1"}, 64'(out_valid1), 64'd1);
    chk({name, ".out_data0"}, out_data0, d0);
    chk({name, ".out_data1"}, out_data1, dff);
    chk({name, ".out_count0"}, 64'(out_count0), 64'(cnt));
    chk({name, ".out_count1"}, 64'(out_count1), 64'(cnt));
  endtask

  // Present one byte, expect it accepted on the next edge; returns #1 after that edge.
  task automatic send_byte(input string name, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    chk_rdy({name, ".pre"}, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [63:0] din;
    logic [63:0] frame;
    logic [63:0] f1, f2;

    vecs[0] = '{8, 1'b0, 64'h1716151413121110, 64'h1716151413121110, 64'h1716151413121110, 4'd8};
    vecs[1] = '{3, 1'b1, 64'h0000000000A3A2A1, 64'h0000000000A3A2A1, 64'hFFFFFFFFFFA3A2A1, 4'd3};
    vecs[2] = '{1, 1'b1, 64'h000000000000005A, 64'h000000000000005A, 64'hFFFFFFFFFFFFFF5A, 4'd1};
    vecs[3] = '{8, 1'b1, 64'h8877665544332211, 64'h8877665544332211, 64'h8877665544332211, 4'd8};
    vecs[4] = '{7, 1'b1, 64'h00C7C6C5C4C3C2C1, 64'h00C7C6C5C4C3C2C1, 64'hFFC7C6C5C4C3C2C1, 4'd7};
    vecs[5] = '{2, 1'b1, 64'h000000000000BEEF, 64'h000000000000BEEF, 64'hFFFFFFFFFFFFBEEF, 4'd2};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;

    // Reset values
    #1;
    chk_rdy("reset", 1'b0);
    chk_idle("reset");
    chk("reset.out_data0", out_data0, 64'h0);
    chk("reset.out_count0", 64'(out_count0), 64'd0);
    chk("reset.out_count1", 64'(out_count1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_rdy("reset.release", 1'b0);
    @(posedge clk);
    #1;
    chk_rdy("reset.first_edge", 1'b1);

    // Table-driven frames, out_ready=1
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      din = vecs[v].din;
      for (int i = 0; i < vecs[v].n; i++) begin
        send_byte($sformatf("vec%0d.b%0d", v, i), din[i*8 +: 8], vecs[v].last && (i == vecs[v].n - 1));
        if (i < vecs[v].n - 1) chk_idle($sformatf("vec%0d.mid%0d", v, i));
      end
      chk_out($sformatf("vec%0d.frame", v), vecs[v].exp0, vecs[v].expff, vecs[v].cnt);
      @(posedge clk);
      #1;
      chk_idle($sformatf("vec%0d.drain", v));
    end

    // Streaming: 24 bytes back to back
    frame = '0;
    for (int j = 0; j < 24; j++) begin
      frame[(j % 8)*8 +: 8] = 8'(8'h20 + j);
      send_byte($sformatf("stream.b%0d", j), 8'(8'h20 + j), 1'b0);
      if (j % 8 == 7) chk_out($sformatf("stream.f%0d", j / 8), frame, frame, 4'd8);
      else            chk_idle($sformatf("stream.c%0d", j));
    end
    @(posedge clk);
    #1;
    chk_idle("stream.drain");

    // Backpressure: two full frames with out_ready=0
    out_ready = 1'b0;
    f1 = 64'h3736353433323130;
    f2 = 64'h4746454443424140;
    for (int j = 0; j < 8; j++) send_byte($sformatf("bp.f1b%0d", j), 8'(8'h30 + j), 1'b0);
    chk_out("bp.f1", f1, f1, 4'd8);
    for (int j = 0; j < 8; j++) begin
      send_byte($sformatf("bp.f2b%0d", j), 8'(8'h40 + j), 1'b0);
      chk_out($sformatf("bp.stable%0d", j), f1, f1, 4'd8);
    end
    chk_rdy("bp.hold", 1'b0);
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_rdy("bp.hold_wait", 1'b0);
      chk_out("bp.hold_stable", f1, f1, 4'd8);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_out("bp.f2", f2, f2, 4'd8);
    chk_rdy("bp.resume", 1'b1);
    @(posedge clk);
    #1;
    chk_out("bp.f2_stable", f2, f2, 4'd8);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("bp.drain");
    send_byte("bp.after", 8'h66, 1'b1);
    chk_out("bp.after", 64'h66, 64'hFFFFFFFFFFFFFF66, 4'd1);
    @(posedge clk);
    #1;

    // Reset mid-frame discards partial data
    for (int j = 0; j < 5; j++) send_byte($sformatf("rst.p%0d", j), 8'(8'h90 + j), 1'b0);
    rst_n = 1'b0;
    #1;
    chk_rdy("rst.mid", 1'b0);
    chk_idle("rst.mid");
    chk("rst.mid.out_data1", out_data1, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_rdy("rst.after", 1'b1);
    for (int j = 0; j < 8; j++) begin
      send_byte($sformatf("rst.b%0d", j), 8'(j), 1'b0);
      if (j < 7) chk_idle($sformatf("rst.c%0d", j));
    end
    chk_out("rst.frame", 64'h0706050403020100, 64'h0706050403020100, 4'd8);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_idle("rst.no_extra");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
